// File: rtl/vp415_video_pkg.sv
// Shared video definitions for the VP415 Pi/AIV pipeline.
// Holds the PAL active-area geometry and the Pi DPI tracker state codes so that
// the Pi-side tracker and the AIV side agree on one set of constants.
package vp415_video_pkg;

    // PAL active area in pixels and lines.
    localparam int unsigned PAL_H_ACTIVE = 720;
    localparam int unsigned PAL_V_ACTIVE = 576;

    // Timing tracker FSM states.
    typedef logic [1:0] trk_state_t;
    localparam trk_state_t TRK_SEARCH  = 2'd0;
    localparam trk_state_t TRK_MEASURE = 2'd1;
    localparam trk_state_t TRK_LOCKED  = 2'd2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a small bundle of asynchronous single-bit inputs.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both stages
//   d_i    - asynchronous inputs
//   q_o    - inputs resynchronised to clk_i (two-cycle latency)
module sync_2ff #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pi_dpi_timing_tracker.sv
// Raspberry Pi DPI timing tracker.
// Synchronises the Pi DPI vsync/DE into sysClk, measures active line length and
// line count each frame, and locks once LOCK_FRAMES consecutive frames match the
// expected geometry. While locked it produces the Pi-side display enable, pixel
// coordinates and a one-pixel frame start flag for the framebuffer reader.
// Ports:
//   sysClk, nReset       - system clock, asynchronous active-low reset
//   sysClkPhase          - free-running 0..7 phase; PIX_PHASE marks a pixel tick
//   pi_hsync/vsync/de    - asynchronous Pi DPI timing inputs
//   displayEnable_pi     - active-area pixel, only while locked
//   frame_start_flag_pi  - first active pixel (0,0) of a frame
//   pixelX_pi, pixelY_pi - active pixel coordinates, 0 outside the active area
//   locked               - geometry locked
//   bad_frames           - saturating count of bad frames seen while locked
module pi_dpi_timing_tracker
    import vp415_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = PAL_H_ACTIVE,
    parameter int unsigned V_ACTIVE      = PAL_V_ACTIVE,
    parameter int unsigned LOCK_FRAMES   = 2,
    parameter logic [2:0]  PIX_PHASE     = 3'd0,
    parameter int unsigned VSYNC_TIMEOUT = 1100000
) (
    input  logic       sysClk,
    input  logic       nReset,
    input  logic [2:0] sysClkPhase,
    input  logic       pi_hsync,
    input  logic       pi_vsync,
    input  logic       pi_de,
    output logic       displayEnable_pi,
    output logic       frame_start_flag_pi,
    output logic [9:0] pixelX_pi,
    output logic [9:0] pixelY_pi,
    output logic       locked,
    output logic [7:0] bad_frames
);

    localparam logic [10:0] H_LEN    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LEN    = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [20:0] WD_LIMIT = 21'(VSYNC_TIMEOUT);

    logic [2:0] pins_sync;
    logic       hs_s, vs_s, de_s;

    sync_2ff #(
        .WIDTH(3)
    ) u_sync (
        .clk_i (sysClk),
        .rst_ni(nReset),
        .d_i   ({pi_hsync, pi_vsync, pi_de}),
        .q_o   (pins_sync)
    );

    assign {hs_s, vs_s, de_s} = pins_sync;

    // hsync is carried through the synchroniser but carries no timing role here.
    logic unused_hs;
    assign unused_hs = hs_s;

    logic        vs_prev_q, de_prev_q;
    logic [10:0] x_cnt_q, x_cnt_d;
    logic [9:0]  y_cnt_q, y_cnt_d;
    logic        frame_bad_q, frame_bad_d;
    logic        skip_line_q, skip_line_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [20:0] wd_q, wd_d;
    trk_state_t  state_q, state_d;
    logic [7:0]  bad_q, bad_d;
    logic        de_out_q, fs_q;
    logic [9:0]  px_q, py_q;

    logic        pix_tick, vs_rise, de_rise, de_fall, frame_good, line_on, en;
    logic [20:0] wd_inc;
    logic [3:0]  good_inc;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;

    always_comb begin
        pix_tick   = (sysClkPhase == PIX_PHASE);
        vs_rise    = vs_s & ~vs_prev_q;
        de_rise    = de_s & ~de_prev_q;
        de_fall    = ~de_s & de_prev_q;
        frame_good = !frame_bad_q && (y_cnt_q == V_LEN);
        wd_inc     = wd_q + 21'd1;
        good_inc   = good_cnt_q + 4'd1;

        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        frame_bad_d = frame_bad_q;
        skip_line_d = skip_line_q;
        good_cnt_d  = good_cnt_q;
        wd_d        = wd_q;
        state_d     = state_q;
        bad_d       = bad_q;

        if (vs_rise) begin
            // Frame boundary takes priority over any DE event on the same tick.
            x_cnt_d     = '0;
            y_cnt_d     = '0;
            frame_bad_d = 1'b0;
            wd_d        = '0;
            // A line already running at vsync is dropped up to its falling edge.
            skip_line_d = de_s && !de_rise;
            case (state_q)
                TRK_MEASURE: begin
                    if (frame_good) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = TRK_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                TRK_LOCKED: begin
                    if (!frame_good) begin
                        state_d    = TRK_MEASURE;
                        good_cnt_d = '0;
                        bad_d      = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;
                    end
                end
                default: begin
                    state_d    = TRK_MEASURE;
                    good_cnt_d = '0;
                end
            endcase
        end else begin
            wd_d = wd_inc;
            if (wd_inc == WD_LIMIT) begin
                state_d    = TRK_SEARCH;
                good_cnt_d = '0;
                wd_d       = '0;
            end
            if (de_fall) begin
                if (skip_line_q) begin
                    skip_line_d = 1'b0;
                end else begin
                    if (x_cnt_q != H_LEN) begin
                        frame_bad_d = 1'b1;
                    end
                    y_cnt_d = (y_cnt_q == 10'h3FF) ? y_cnt_q : y_cnt_q + 10'd1;
                end
            end
        end

        // x_cnt holds the DE-high ticks seen so far, so the current pixel's
        // index is its value before this tick (zero on the rising edge).
        pix_x   = de_rise ? 11'd0 : x_cnt_q;
        pix_y   = vs_rise ? 10'd0 : y_cnt_q;
        line_on = de_s && !skip_line_d;
        if (line_on) begin
            x_cnt_d = (pix_x == 11'h7FF) ? pix_x : pix_x + 11'd1;
        end

        // Must be locked both before and after this tick, so a bad closing
        // frame or a watchdog expiry suppresses the pixel.
        en = (state_q == TRK_LOCKED) && (state_d == TRK_LOCKED) && line_on &&
             (pix_x < H_LEN) && (pix_y < V_LEN);
    end

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            vs_prev_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            frame_bad_q <= 1'b0;
            skip_line_q <= 1'b0;
            good_cnt_q  <= '0;
            wd_q        <= '0;
            state_q     <= TRK_SEARCH;
            bad_q       <= '0;
            de_out_q    <= 1'b0;
            fs_q        <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
        end else if (pix_tick) begin
            vs_prev_q   <= vs_s;
            de_prev_q   <= de_s;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            frame_bad_q <= frame_bad_d;
            skip_line_q <= skip_line_d;
            good_cnt_q  <= good_cnt_d;
            wd_q        <= wd_d;
            state_q     <= state_d;
            bad_q       <= bad_d;
            de_out_q    <= en;
            fs_q        <= en && (pix_x == 11'd0) && (pix_y == 10'd0);
            px_q        <= en ? pix_x[9:0] : 10'd0;
            py_q        <= en ? pix_y : 10'd0;
        end
    end

    assign displayEnable_pi    = de_out_q;
    assign frame_start_flag_pi = fs_q;
    assign pixelX_pi           = px_q;
    assign pixelY_pi           = py_q;
    assign locked              = (state_q == TRK_LOCKED);
    assign bad_frames          = bad_q;

endmodule
